// File: rtl/if_fetch_stage_pkg.sv
// Shared CPU definitions for the RV32 front end: NOP encoding, default reset
// vector and the fetch-stage state encoding.
package if_fetch_stage_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register with flush > stall > load > bubble priority.
// Written generically so later pipeline registers can reuse the pattern.
module if_id_reg
  import if_fetch_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] inst_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] inst_o
);

  logic            valid_d, valid_q;
  logic [XLEN-1:0] pc_d, pc_q;
  logic [XLEN-1:0] inst_d, inst_q;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (flush_i) begin
      valid_d = 1'b0;
      pc_d    = '0;
      inst_d  = NOP_INST;
    end else if (!stall_i) begin
      if (load_i) begin
        valid_d = 1'b1;
        pc_d    = pc_i;
        inst_d  = inst_i;
      end else begin
        valid_d = 1'b0;
        pc_d    = '0;
        inst_d  = NOP_INST;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= NOP_INST;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: single-outstanding instruction-memory requests,
// redirect handling (including in-flight responses) and a 1-entry skid buffer.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_pc_i,
  output logic            im_req_o,
  output logic [XLEN-1:0] im_addr_o,
  input  logic            im_rvalid_i,
  input  logic [XLEN-1:0] im_rdata_i,
  output logic            id_valid_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_inst_o
);

  fetch_state_e    state_d, state_q;
  logic [XLEN-1:0] req_addr_d, req_addr_q;
  logic [XLEN-1:0] next_pc_d, next_pc_q;
  logic [XLEN-1:0] hold_inst_d, hold_inst_q;
  logic            im_req_d, im_req_q;

  logic            deliver;
  logic [XLEN-1:0] deliver_inst;
  logic [XLEN-1:0] flush_tgt;
  logic [XLEN-1:0] seq_pc;

  assign flush_tgt = flush_pc_i & ~{{(XLEN-2){1'b0}}, 2'b11};
  assign seq_pc    = req_addr_q + {{(XLEN-3){1'b0}}, 3'b100};

  // A request can never be withdrawn, so a flush that arrives before its
  // response parks the target in next_pc and waits out the response (DROP).
  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    next_pc_d    = next_pc_q;
    hold_inst_d  = hold_inst_q;
    deliver      = 1'b0;
    deliver_inst = im_rdata_i;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (flush_i) begin
          if (im_rvalid_i) begin
            req_addr_d = flush_tgt;
          end else begin
            next_pc_d = flush_tgt;
            state_d   = ST_DROP;
          end
        end else if (im_rvalid_i) begin
          if (stall_i) begin
            hold_inst_d = im_rdata_i;
            state_d     = ST_HOLD;
          end else begin
            deliver    = 1'b1;
            req_addr_d = seq_pc;
          end
        end
      end
      ST_DROP: begin
        if (im_rvalid_i) begin
          req_addr_d = flush_i ? flush_tgt : next_pc_q;
          state_d    = ST_REQ;
        end else if (flush_i) begin
          next_pc_d = flush_tgt;
        end
      end
      ST_HOLD: begin
        if (flush_i) begin
          req_addr_d = flush_tgt;
          state_d    = ST_REQ;
        end else if (!stall_i) begin
          deliver      = 1'b1;
          deliver_inst = hold_inst_q;
          req_addr_d   = seq_pc;
          state_d      = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    im_req_d = (state_d == ST_REQ) || (state_d == ST_DROP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_addr_q  <= RESET_PC;
      next_pc_q   <= RESET_PC;
      hold_inst_q <= NOP_INST;
      im_req_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      next_pc_q   <= next_pc_d;
      hold_inst_q <= hold_inst_d;
      im_req_q    <= im_req_d;
    end
  end

  assign im_req_o  = im_req_q;
  assign im_addr_o = req_addr_q;

  if_id_reg #(
    .XLEN(XLEN)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .stall_i (stall_i),
    .load_i  (deliver),
    .pc_i    (req_addr_q),
    .inst_i  (deliver_inst),
    .valid_o (id_valid_o),
    .pc_o    (id_pc_o),
    .inst_o  (id_inst_o)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios followed by randomized
// stall/flush/latency traffic, checked against a transaction-level model.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] WRAPPC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = '0;
  logic        im_req_o;
  logic [31:0] im_addr_o;
  logic        im_rvalid_i = 1'b0;
  logic [31:0] im_rdata_i = '0;
  logic        id_valid_o;
  logic [31:0] id_pc_o, id_inst_o;

  logic        im_req_w, id_valid_w;
  logic [31:0] im_addr_w, id_pc_w, id_inst_w, im_rdata_w;
  logic        zero_b = 1'b0;
  logic [31:0] zero_w = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  if_fetch_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .flush_pc_i(flush_pc_i), .im_req_o(im_req_o), .im_addr_o(im_addr_o),
    .im_rvalid_i(im_rvalid_i), .im_rdata_i(im_rdata_i),
    .id_valid_o(id_valid_o), .id_pc_o(id_pc_o), .id_inst_o(id_inst_o)
  );

  // Second instance with a wrapping reset vector and a zero-wait memory.
  assign im_rdata_w = mem_word(im_addr_w);
  if_fetch_stage #(.XLEN(32), .RESET_PC(WRAPPC)) dut_w (
    .clk(clk), .rst_n(rst_n), .stall_i(zero_b), .flush_i(zero_b),
    .flush_pc_i(zero_w), .im_req_o(im_req_w), .im_addr_o(im_addr_w),
    .im_rvalid_i(im_req_w), .im_rdata_i(im_rdata_w),
    .id_valid_o(id_valid_w), .id_pc_o(id_pc_w), .id_inst_o(id_inst_w)
  );

  // Reference model state: expected outputs plus the transaction bookkeeping.
  bit          started, kill, buf_full, e_req, e_valid, p_valid, rand_lat;
  logic [31:0] e_addr, e_pc, e_inst, target, buf_inst, s_expect, p_pc;
  int          age, lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    started = 0; kill = 0; buf_full = 0; e_req = 0; e_valid = 0; p_valid = 0;
    e_addr = RST_PC; e_pc = '0; e_inst = NOP; target = RST_PC; buf_inst = NOP;
    s_expect = RST_PC; p_pc = '0; age = 0;
  endtask

  task automatic model_update();
    bit          dlv;
    logic [31:0] dinst, dpc, tgt;
    dlv = 0; dinst = '0; dpc = '0;
    tgt = {flush_pc_i[31:2], 2'b00};
    if (!started) begin
      started = 1; e_req = 1;
    end else if (buf_full) begin
      if (flush_i) begin
        buf_full = 0; e_addr = tgt; e_req = 1;
      end else if (!stall_i) begin
        dlv = 1; dpc = e_addr; dinst = buf_inst;
        e_addr = e_addr + 32'd4; buf_full = 0; e_req = 1;
      end
    end else if (kill) begin
      if (im_rvalid_i) begin
        kill = 0; e_addr = flush_i ? tgt : target;
      end else if (flush_i) begin
        target = tgt;
      end
    end else if (flush_i) begin
      if (im_rvalid_i) e_addr = tgt;
      else begin kill = 1; target = tgt; end
    end else if (im_rvalid_i) begin
      if (stall_i) begin
        buf_full = 1; buf_inst = im_rdata_i; e_req = 0;
      end else begin
        dlv = 1; dpc = e_addr; dinst = im_rdata_i; e_addr = e_addr + 32'd4;
      end
    end
    if (flush_i) begin
      e_valid = 0; e_pc = '0; e_inst = NOP; s_expect = tgt;
    end else if (!stall_i) begin
      if (dlv) begin e_valid = 1; e_pc = dpc; e_inst = dinst; end
      else begin e_valid = 0; e_pc = '0; e_inst = NOP; end
    end
  endtask

  task automatic compare();
    chk("im_req", 32'(im_req_o), 32'(e_req));
    chk("im_addr", im_addr_o, e_addr);
    chk("id_valid", 32'(id_valid_o), 32'(e_valid));
    chk("id_pc", id_pc_o, e_pc);
    chk("id_inst", id_inst_o, e_inst);
    // Every newly presented instruction must continue program order.
    if (id_valid_o && (!p_valid || p_pc != id_pc_o)) begin
      chk("stream_pc", id_pc_o, s_expect);
      chk("stream_inst", id_inst_o, mem_word(id_pc_o));
      s_expect = id_pc_o + 32'd4;
    end
    p_valid = id_valid_o;
    p_pc    = id_pc_o;
  endtask

  // One clock cycle; entered and left at posedge+1.
  task automatic tick(input logic s, input logic f, input logic [31:0] fp);
    stall_i = s; flush_i = f; flush_pc_i = fp;
    if (im_req_o) begin
      age++;
      if (age == 1 && rand_lat) lat = $urandom_range(1, 4);
      im_rvalid_i = (age >= lat);
    end else begin
      age = 0;
      im_rvalid_i = 1'b0;
    end
    im_rdata_i = im_rvalid_i ? mem_word(im_addr_o) : $urandom;
    @(negedge clk);
    compare();
    model_update();
    if (im_rvalid_i) age = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall_i = 0; flush_i = 0; im_rvalid_i = 0;
    #1;
    chk("rst_im_req", 32'(im_req_o), 32'd0);
    chk("rst_im_addr", im_addr_o, RST_PC);
    chk("rst_id_valid", 32'(id_valid_o), 32'd0);
    chk("rst_id_pc", id_pc_o, 32'd0);
    chk("rst_id_inst", id_inst_o, NOP);
    chk("rst_w_req", 32'(im_req_w), 32'd0);
    chk("rst_w_addr", im_addr_w, WRAPPC);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rand_lat = 0; lat = 1;
    model_reset();
    #2;
    do_reset();

    // Back-to-back 1-cycle fetches, wrap instance checked alongside.
    tick(0, 0, 0);
    chk("w_req", 32'(im_req_w), 32'd1);
    chk("w_addr0", im_addr_w, WRAPPC);
    tick(0, 0, 0);
    chk("w_addr1", im_addr_w, 32'd0);
    chk("w_id_pc0", id_pc_w, WRAPPC);
    chk("w_id_valid", 32'(id_valid_w), 32'd1);
    tick(0, 0, 0);
    chk("w_id_pc1", id_pc_w, 32'd0);
    chk("w_id_inst1", id_inst_w, mem_word(32'd0));

    // Stall while the response for 0x8 arrives.
    tick(1, 0, 0); tick(1, 0, 0); tick(1, 0, 0);
    chk("hold_req", 32'(im_req_o), 32'd0);
    chk("hold_id_pc", id_pc_o, 32'h4);
    tick(0, 0, 0);
    chk("unhold_id_pc", id_pc_o, 32'h8);
    tick(0, 0, 0);

    // 3-cycle memory, flush while 0x10 is outstanding.
    lat = 3;
    tick(0, 1, 32'h100); tick(0, 0, 0); tick(0, 0, 0);
    chk("drop_addr", im_addr_o, 32'h100);
    tick(0, 1, 32'h180); tick(0, 1, 32'h200); tick(0, 0, 0);
    chk("drop2_addr", im_addr_o, 32'h200);

    // Flush together with stall, unaligned target.
    lat = 1;
    tick(0, 0, 0); tick(0, 0, 0);
    tick(1, 1, 32'h103);
    chk("fs_valid", 32'(id_valid_o), 32'd0);
    chk("fs_inst", id_inst_o, NOP);
    chk("fs_addr", im_addr_o, 32'h100);

    // Flush on the same cycle as the response for 0x20.
    tick(0, 1, 32'h20);
    tick(0, 1, 32'h40);
    chk("frv_addr", im_addr_o, 32'h40);
    chk("frv_valid", 32'(id_valid_o), 32'd0);
    tick(0, 0, 0); tick(0, 0, 0);

    // Asynchronous reset with a request outstanding.
    lat = 3;
    tick(0, 0, 0); tick(0, 0, 0);
    do_reset();
    lat = 1;
    for (int i = 0; i < 4; i++) tick(0, 0, 0);

    // Randomized traffic.
    rand_lat = 1;
    for (int i = 0; i < 3000; i++)
      tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), $urandom);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage feeding the IF/ID pipeline register of the 5-stage RV32 core.
- Consumes the stall and flush outputs of the hazard unit, and the redirect target selected in EXE (branch/jump) or CSR (trap vector / mepc).
- Drives a single-outstanding-request instruction-memory port (CPU-wrapper side of the AXI master) and absorbs its variable latency.
- Handles requests that are still outstanding when a flush arrives.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- XLEN, 32, address/instruction width

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- stall_i  in  1  hold IF/ID (load-use stall OR data-memory busy)
- flush_i  in  1  redirect; kill younger instructions
- flush_pc_i  in  XLEN  redirect target, valid with flush_i
- im_req_o  out  1  instruction request
- im_addr_o  out  XLEN  request address, stable while im_req_o=1 until im_rvalid_i
- im_rvalid_i  in  1  one-cycle pulse, data valid, only while im_req_o=1
- im_rdata_i  in  XLEN  instruction word
- id_valid_o  out  1  IF/ID holds a real instruction
- id_pc_o  out  XLEN  PC of IF/ID instruction
- id_inst_o  out  XLEN  IF/ID instruction (NOP when bubble)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, req_addr=RESET_PC, next_pc=RESET_PC.
  - id_valid_o=0, id_pc_o=0, id_inst_o=NOP (32'h0000_0013), im_req_o=0.
- Registers:
  - req_addr: address of the in-flight request.
  - next_pc: target held during DROP.
  - hold_inst: 1-entry skid buffer.
- PC arithmetic:
  - Sequential PC = req_addr+4, modulo 2^32; 0xFFFF_FFFC wraps to 0.
  - flush_pc_i[1:0] forced to 0.
- IF/ID update rule, in priority order:
  - flush_i: load bubble (valid=0, inst=NOP, pc=0).
  - else stall_i: hold.
  - else new instruction delivered this cycle: load it with valid=1.
  - else: load bubble.
- IDLE: im_req_o=0; always → REQ next cycle, so first request issues 1 cycle after rst_n rises.
- REQ: im_req_o=1, im_addr_o=req_addr.
  - rvalid & flush: discard data; req_addr←flush_pc; stay REQ.
  - flush & ~rvalid: next_pc←flush_pc; → DROP. Request stays asserted; the address cannot be withdrawn.
  - rvalid & ~flush & ~stall: deliver {req_addr, rdata}; req_addr←req_addr+4; stay REQ. Back-to-back: the new address is presented the next cycle.
  - rvalid & stall & ~flush: hold_inst←rdata; → HOLD.
  - neither: stay REQ.
- DROP: im_req_o=1, im_addr_o=old req_addr.
  - Another flush updates next_pc; the latest flush wins.
  - On rvalid: discard data; req_addr←next_pc (or flush_pc_i if flush_i in the same cycle); → REQ.
- HOLD: im_req_o=0.
  - flush: discard hold_inst; req_addr←flush_pc; → REQ.
  - ~stall: deliver {req_addr, hold_inst}; req_addr←req_addr+4; → REQ.
  - stall: stay HOLD.
- Latencies:
  - Redirect: flush at cycle t → im_addr_o=target at t+1 (REQ/HOLD), or on the cycle after the dropped response (DROP).
  - Fetch: instruction visible on id_* the cycle after im_rvalid_i.
- A discarded response never sets id_valid_o.
- Reset mid-transaction returns to reset values; the memory side is reset by the same rst_n.

Decomposition:
- Shared CPU definitions package:
  - NOP_INST constant (32'h0000_0013).
  - Default RESET_PC.
  - Fetch-state enum (IDLE, REQ, DROP, HOLD), 2 bits.
- Sub-module if_id_reg: IF/ID register with the flush>stall>load>bubble priority above. Reusable pattern for the later pipeline registers.

Test Plan:
- Reset release, 1-cycle memory → im_addr_o 0x0,0x4,0x8 on consecutive cycles; id_pc_o 0x0,0x4,0x8 with id_valid_o=1 one cycle later each; no bubbles.
- stall_i=1 for 3 cycles while response for 0x8 arrives → HOLD; im_req_o=0; id_pc_o stays 0x4. Stall drops → id_pc_o=0x8 next cycle, then request 0xC.
- 3-cycle memory, flush_i with flush_pc_i=0x100 in the first cycle of request 0x10:
  - im_addr_o stays 0x10 until rvalid, data discarded, id_valid_o=0 throughout.
  - Next im_addr_o=0x100.
  - A second flush to 0x200 during DROP → next address 0x200.
- flush_i and stall_i both high → IF/ID becomes bubble (valid 0, NOP). flush_pc_i=0x103 → request address 0x100.
- flush_i same cycle as im_rvalid_i for 0x20, target 0x40 → 0x20 never reaches ID; im_addr_o=0x40 next cycle.
- RESET_PC=0xFFFF_FFFC → fetch 0xFFFF_FFFC then 0x0. Assert rst_n=0 during an outstanding request → outputs return to reset values asynchronously; fetch restarts at RESET_PC.
